alu_control_sequencer: RTL and testbench

Hardwired control sequencer that drives the ALU's control inputs and consumes its zero and carry flags. It steps a T-state counter through fetch and execute, decodes the 4-bit opcode held in the instruction register, and emits the active-low bus and register enables for the 8-bit datapath. It also resolves conditional jumps from the registered flags. It sits between the instruction register, the flags outputs of the ALU, and every bus participant (PC, MAR, RAM, A, B, ALU, output register).

---
 rtl/alu_control_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_alu_control_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_control_sequencer.sv
// Hardwired T-state sequencer: decodes the opcode nibble into active-low datapath enables, one step per clock.
// Enables are combinational from the registered T-state; optional macro SEQ_SKIP_EMPTY_TSTATES_EN ends instructions early.
module alu_control_sequencer #(
  parameter int OPCODE_WIDTH = 4
) (
  input  logic       i_CLOCK,
  input  logic       i_CLEAR_n,
  input  logic [7:0] i_INSTR,
  input  logic       i_ZERO_FLAG,
  input  logic       i_CARRY_FLAG,
  output logic       o_PC_OUT_n,
  output logic       o_PC_INC_n,
  output logic       o_PC_LOAD_n,
  output logic       o_MAR_IN_n,
  output logic       o_RAM_IN_n,
  output logic       o_RAM_OUT_n,
  output logic       o_IR_IN_n,
  output logic       o_IR_OUT_n,
  output logic       o_A_IN_n,
  output logic       o_A_OUT_n,
  output logic       o_B_IN_n,
  output logic       o_ALU_OUT_n,
  output logic       o_SUB,
  output logic       o_UPDATE_FLAGS_n,
  output logic       o_OUT_IN_n,
  output logic       o_HALT,
  output logic [2:0] o_TSTATE
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP = OPCODE_WIDTH'(4'h0);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'h1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h3);
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4'h4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(4'h5);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(4'h6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(4'h7);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(4'h8);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'hE);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF);

  tstate_t                 r_tstate;
  tstate_t                 w_tstate_nxt;
  logic                    r_halt;
  logic                    w_halt_nxt;
  logic                    w_last;
  logic [OPCODE_WIDTH-1:0] w_opcode;
  logic                    w_unused_operand;

  assign w_opcode         = i_INSTR[7 -: OPCODE_WIDTH];
  assign w_unused_operand = ^i_INSTR[7-OPCODE_WIDTH:0];

`ifdef SEQ_SKIP_EMPTY_TSTATES_EN
  tstate_t w_last_step;

  // HLT maps to T4 so it never short-circuits; it freezes at T3 instead.
  always_comb begin
    w_last_step = T1;
    case (w_opcode)
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT: w_last_step = T2;
      OP_LDA, OP_STA:                       w_last_step = T3;
      OP_ADD, OP_SUB, OP_HLT:               w_last_step = T4;
      default:                              w_last_step = T1;
    endcase
  end

  assign w_last = (r_tstate == w_last_step);
`else
  assign w_last = 1'b0;
`endif

  always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
    if (!i_CLEAR_n) begin
      r_tstate <= T0;
      r_halt   <= 1'b0;
    end else begin
      r_tstate <= w_tstate_nxt;
      r_halt   <= w_halt_nxt;
    end
  end

  always_comb begin
    w_tstate_nxt = r_tstate;
    w_halt_nxt   = r_halt;
    if (!r_halt) begin
      if (r_tstate == T2 && w_opcode == OP_HLT) begin
        w_halt_nxt   = 1'b1;
        w_tstate_nxt = T3;
      end else if (r_tstate == T4 || w_last) begin
        w_tstate_nxt = T0;
      end else begin
        w_tstate_nxt = tstate_t'(r_tstate + 3'd1);
      end
    end
  end

  // Reset gates the decode so T0 enables do not leak while clear is held.
  always_comb begin
    o_PC_OUT_n       = 1'b1;
    o_PC_INC_n       = 1'b1;
    o_PC_LOAD_n      = 1'b1;
    o_MAR_IN_n       = 1'b1;
    o_RAM_IN_n       = 1'b1;
    o_RAM_OUT_n      = 1'b1;
    o_IR_IN_n        = 1'b1;
    o_IR_OUT_n       = 1'b1;
    o_A_IN_n         = 1'b1;
    o_A_OUT_n        = 1'b1;
    o_B_IN_n         = 1'b1;
    o_ALU_OUT_n      = 1'b1;
    o_SUB            = 1'b0;
    o_UPDATE_FLAGS_n = 1'b1;
    o_OUT_IN_n       = 1'b1;
    if (i_CLEAR_n && !r_halt) begin
      case (r_tstate)
        T0: begin
          o_PC_OUT_n = 1'b0;
          o_MAR_IN_n = 1'b0;
        end
        T1: begin
          o_RAM_OUT_n = 1'b0;
          o_IR_IN_n   = 1'b0;
          o_PC_INC_n  = 1'b0;
        end
        T2: begin
          case (w_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              o_IR_OUT_n = 1'b0;
              o_MAR_IN_n = 1'b0;
            end
            OP_LDI: begin
              o_IR_OUT_n = 1'b0;
              o_A_IN_n   = 1'b0;
            end
            OP_JMP: begin
              o_IR_OUT_n  = 1'b0;
              o_PC_LOAD_n = 1'b0;
            end
            OP_JC: begin
              o_IR_OUT_n  = 1'b0;
              o_PC_LOAD_n = ~i_CARRY_FLAG;
            end
            OP_JZ: begin
              o_IR_OUT_n  = 1'b0;
              o_PC_LOAD_n = ~i_ZERO_FLAG;
            end
            OP_OUT: begin
              o_A_OUT_n  = 1'b0;
              o_OUT_IN_n = 1'b0;
            end
            default: ;
          endcase
        end
        T3: begin
          case (w_opcode)
            OP_LDA: begin
              o_RAM_OUT_n = 1'b0;
              o_A_IN_n    = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              o_RAM_OUT_n = 1'b0;
              o_B_IN_n    = 1'b0;
            end
            OP_STA: begin
              o_A_OUT_n  = 1'b0;
              o_RAM_IN_n = 1'b0;
            end
            default: ;
          endcase
        end
        T4: begin
          if (w_opcode == OP_ADD || w_opcode == OP_SUB) begin
            o_ALU_OUT_n      = 1'b0;
            o_A_IN_n         = 1'b0;
            o_UPDATE_FLAGS_n = 1'b0;
            o_SUB            = (w_opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_HALT   = r_halt;
  assign o_TSTATE = r_tstate;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer; control outputs packed into one vector and compared as XOR masks over idle.
module tb_alu_control_sequencer;

  logic       clk;
  logic       clear_n;
  logic [7:0] instr;
  logic       zf;
  logic       cf;
  logic       pco, pci, pcl, mari, rami, ramo, iri, iro, ai, ao, bi, aluo, sub, upd, outi, halt;
  logic [2:0] tstate;

  int checks   = 0;
  int failures = 0;

  localparam logic [14:0] C_PCO  = 15'h4000;
  localparam logic [14:0] C_PCI  = 15'h2000;
  localparam logic [14:0] C_PCL  = 15'h1000;
  localparam logic [14:0] C_MAR  = 15'h0800;
  localparam logic [14:0] C_RAMI = 15'h0400;
  localparam logic [14:0] C_RAMO = 15'h0200;
  localparam logic [14:0] C_IRI  = 15'h0100;
  localparam logic [14:0] C_IRO  = 15'h0080;
  localparam logic [14:0] C_AI   = 15'h0040;
  localparam logic [14:0] C_AO   = 15'h0020;
  localparam logic [14:0] C_BI   = 15'h0010;
  localparam logic [14:0] C_ALU  = 15'h0008;
  localparam logic [14:0] C_SUB  = 15'h0004;
  localparam logic [14:0] C_UPD  = 15'h0002;
  localparam logic [14:0] C_OUTI = 15'h0001;
  localparam logic [14:0] IDLE   = 15'h7FFB;
  localparam logic [14:0] M_T0   = C_PCO | C_MAR;
  localparam logic [14:0] M_T1   = C_RAMO | C_IRI | C_PCI;

  alu_control_sequencer dut (
    .i_CLOCK         (clk),
    .i_CLEAR_n       (clear_n),
    .i_INSTR         (instr),
    .i_ZERO_FLAG     (zf),
    .i_CARRY_FLAG    (cf),
    .o_PC_OUT_n      (pco),
    .o_PC_INC_n      (pci),
    .o_PC_LOAD_n     (pcl),
    .o_MAR_IN_n      (mari),
    .o_RAM_IN_n      (rami),
    .o_RAM_OUT_n     (ramo),
    .o_IR_IN_n       (iri),
    .o_IR_OUT_n      (iro),
    .o_A_IN_n        (ai),
    .o_A_OUT_n       (ao),
    .o_B_IN_n        (bi),
    .o_ALU_OUT_n     (aluo),
    .o_SUB           (sub),
    .o_UPDATE_FLAGS_n(upd),
    .o_OUT_IN_n      (outi),
    .o_HALT          (halt),
    .o_TSTATE        (tstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [14:0] mask, input logic [2:0] exp_t, input logic exp_h);
    logic [18:0] obs;
    logic [18:0] expv;
    obs  = {pco, pci, pcl, mari, rami, ramo, iri, iro, ai, ao, bi, aluo, sub, upd, outi, tstate, halt};
    expv = {IDLE ^ mask, exp_t, exp_h};
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: ctrl/t/halt observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifndef SEQ_SKIP_EMPTY_TSTATES_EN
  // Runs one full 5-cycle instruction starting and ending at T0.
  task automatic do_instr(input string tag, input logic [7:0] op,
                          input logic [14:0] m2, input logic [14:0] m3, input logic [14:0] m4);
    instr = op;
    #0;
    check({tag, "_t0"}, M_T0, 3'd0, 1'b0); step();
    check({tag, "_t1"}, M_T1, 3'd1, 1'b0); step();
    check({tag, "_t2"}, m2,   3'd2, 1'b0); step();
    check({tag, "_t3"}, m3,   3'd3, 1'b0); step();
    check({tag, "_t4"}, m4,   3'd4, 1'b0); step();
  endtask
`endif

  initial begin
    clear_n = 1'b0;
    instr   = 8'h00;
    zf      = 1'b0;
    cf      = 1'b0;
    #12;
    check("reset_held", 15'h0, 3'd0, 1'b0);
    clear_n = 1'b1;
    #1;

`ifndef SEQ_SKIP_EMPTY_TSTATES_EN
    do_instr("nop_a", 8'h00, 15'h0, 15'h0, 15'h0);
    do_instr("nop_b", 8'h00, 15'h0, 15'h0, 15'h0);
    do_instr("add",   8'h2A, C_IRO | C_MAR, C_RAMO | C_BI, C_ALU | C_AI | C_UPD);
    do_instr("sub",   8'h3A, C_IRO | C_MAR, C_RAMO | C_BI, C_ALU | C_AI | C_UPD | C_SUB);
    do_instr("lda",   8'h1E, C_IRO | C_MAR, C_RAMO | C_AI, 15'h0);
    do_instr("sta",   8'h4E, C_IRO | C_MAR, C_AO | C_RAMI, 15'h0);
    do_instr("ldi",   8'h57, C_IRO | C_AI, 15'h0, 15'h0);
    do_instr("jmp",   8'h63, C_IRO | C_PCL, 15'h0, 15'h0);
    cf = 1'b1; zf = 1'b0;
    do_instr("jc_taken",  8'h75, C_IRO | C_PCL, 15'h0, 15'h0);
    do_instr("jz_nz",     8'h85, C_IRO, 15'h0, 15'h0);
    cf = 1'b0; zf = 1'b1;
    do_instr("jc_nc",     8'h75, C_IRO, 15'h0, 15'h0);
    do_instr("jz_taken",  8'h85, C_IRO | C_PCL, 15'h0, 15'h0);
    zf = 1'b0;
    do_instr("out",   8'hE0, C_AO | C_OUTI, 15'h0, 15'h0);
    do_instr("inv_a", 8'hA5, 15'h0, 15'h0, 15'h0);
`else
    instr = 8'h57;
    #0;
    check("sk_ldi_t0", M_T0, 3'd0, 1'b0); step();
    check("sk_ldi_t1", M_T1, 3'd1, 1'b0); step();
    check("sk_ldi_t2", C_IRO | C_AI, 3'd2, 1'b0);
    instr = 8'h00;
    step();
    check("sk_nop_t0", M_T0, 3'd0, 1'b0); step();
    check("sk_nop_t1", M_T1, 3'd1, 1'b0);
    instr = 8'h2A;
    step();
    check("sk_add_t0", M_T0, 3'd0, 1'b0); step();
    check("sk_add_t1", M_T1, 3'd1, 1'b0); step();
    check("sk_add_t2", C_IRO | C_MAR, 3'd2, 1'b0); step();
    check("sk_add_t3", C_RAMO | C_BI, 3'd3, 1'b0); step();
    check("sk_add_t4", C_ALU | C_AI | C_UPD, 3'd4, 1'b0); step();
    check("sk_add_end", M_T0, 3'd0, 1'b0);
`endif

    // Clear pulsed in the middle of LDA's T3.
    instr = 8'h1E;
    #0;
    check("lda_t0", M_T0, 3'd0, 1'b0); step();
    check("lda_t1", M_T1, 3'd1, 1'b0); step();
    check("lda_t2", C_IRO | C_MAR, 3'd2, 1'b0); step();
    check("lda_t3", C_RAMO | C_AI, 3'd3, 1'b0);
    #2;
    clear_n = 1'b0;
    #1;
    check("lda_clr_held", 15'h0, 3'd0, 1'b0);
    #1;
    clear_n = 1'b1;
    #1;
    check("lda_clr_rel", M_T0, 3'd0, 1'b0);
    step();
    check("lda_clr_t1", M_T1, 3'd1, 1'b0);
    step();
    check("post_clr_t2", C_IRO | C_MAR, 3'd2, 1'b0);
    step(); step(); step();

    instr = 8'hF0;
    #0;
    check("hlt_t0", M_T0, 3'd0, 1'b0); step();
    check("hlt_t1", M_T1, 3'd1, 1'b0); step();
    check("hlt_t2", 15'h0, 3'd2, 1'b0); step();
    for (int i = 0; i < 20; i++) begin
      check("hlt_frozen", 15'h0, 3'd3, 1'b1);
      step();
    end
    #2;
    clear_n = 1'b0;
    #1;
    check("hlt_clr_held", 15'h0, 3'd0, 1'b0);
    clear_n = 1'b1;
    #1;
    check("hlt_clr_rel", M_T0, 3'd0, 1'b0);
    step();
    check("hlt_restart_t1", M_T1, 3'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
